// File: rtl/spine_router.sv
// spine_router: group-level spine switch terminating the four leaf spine links plus the uplink.
// Per-input FIFOs, destination routing, per-output round-robin arbitration, registered outputs.
module spine_router #(
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  GROUP_ID   = 4'b0101
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arb_enable,
    input  logic [5*DWIDTH-1:0] in_data,
    input  logic [4:0]          in_valid,
    input  logic [29:0]         in_dest_addr,
    output logic [5*DWIDTH-1:0] out_data,
    output logic [4:0]          out_valid,
    output logic [29:0]         out_dest_addr,
    output logic [4:0]          fifo_full,
    output logic [4:0]          fifo_empty,
    output logic [7:0]          drop_count,
    output logic                busy,
    output logic [24:0]         grant_vec
);
    localparam int unsigned NP = 5;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DWIDTH + 6;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [EW-1:0]     r_mem [NP][FIFO_DEPTH];
    logic [AW-1:0]     r_wptr [NP];
    logic [AW-1:0]     r_rptr [NP];
    logic [AW:0]       r_cnt  [NP];
    logic [NP-1:0]     r_push_d;
    logic [2:0]        r_ptr  [NP];
    logic [DWIDTH-1:0] r_out_data [NP];
    logic [5:0]        r_out_dest [NP];
    logic [NP-1:0]     r_out_valid;
    logic [24:0]       r_grant;
    logic [7:0]        r_drops;

    logic [EW-1:0]     w_head [NP];
    logic [2:0]        w_tgt  [NP];
    logic [2:0]        w_win  [NP];
    logic [NP-1:0]     w_ready;
    logic [NP-1:0]     w_in_grp;
    logic [NP-1:0]     w_push;
    logic [NP-1:0]     w_pop;
    logic [NP-1:0]     w_any;
    logic [24:0]       w_grant;
    logic              w_misroute;
    logic [2:0]        w_ndrop;
    logic [8:0]        w_drop_sum;

    // An entry pushed at the last edge is not yet eligible, giving the two-cycle minimum latency.
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            w_head[i]   = r_mem[i][r_rptr[i]];
            w_in_grp[i] = (w_head[i][EW-1 -: 4] == GROUP_ID);
            w_tgt[i]    = w_in_grp[i] ? {1'b0, w_head[i][EW-5 -: 2]} : 3'd4;
            w_ready[i]  = (r_cnt[i] > (AW+1)'(r_push_d[i]));
            w_push[i]   = in_valid[i] && (r_cnt[i] != FULL_CNT);
        end
    end

    assign w_misroute = arb_enable && w_ready[NP-1] && !w_in_grp[NP-1];

    always_comb begin
        int unsigned v_idx;
        v_idx   = 0;
        w_any   = '0;
        w_grant = '0;
        for (int unsigned o = 0; o < NP; o++) begin
            w_win[o] = '0;
            for (int unsigned j = 1; j <= NP; j++) begin
                v_idx = (32'(r_ptr[o]) + j) % NP;
                if (!w_any[o] && arb_enable && w_ready[v_idx] && (w_tgt[v_idx] == 3'(o)) &&
                    !((v_idx == NP-1) && !w_in_grp[NP-1])) begin
                    w_any[o] = 1'b1;
                    w_win[o] = 3'(v_idx);
                end
            end
            if (w_any[o])
                w_grant[o*NP + 32'(w_win[o])] = 1'b1;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int unsigned o = 0; o < NP; o++)
            if (w_any[o])
                w_pop[w_win[o]] = 1'b1;
        if (w_misroute)
            w_pop[NP-1] = 1'b1;
    end

    always_comb begin
        w_ndrop = 3'(w_misroute);
        for (int unsigned i = 0; i < NP; i++)
            if (in_valid[i] && !w_push[i])
                w_ndrop = w_ndrop + 3'd1;
        w_drop_sum = {1'b0, r_drops} + {6'b0, w_ndrop};
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NP; i++)
            if (!reset && w_push[i])
                r_mem[i][r_wptr[i]] <= {in_dest_addr[i*6 +: 6], in_data[i*DWIDTH +: DWIDTH]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NP; i++) begin
                r_wptr[i]     <= '0;
                r_rptr[i]     <= '0;
                r_cnt[i]      <= '0;
                r_ptr[i]      <= 3'd4;
                r_out_data[i] <= '0;
                r_out_dest[i] <= '0;
            end
            r_push_d    <= '0;
            r_out_valid <= '0;
            r_grant     <= '0;
            r_drops     <= '0;
        end else begin
            for (int unsigned i = 0; i < NP; i++) begin
                if (w_push[i])
                    r_wptr[i] <= r_wptr[i] + AW'(1);
                if (w_pop[i])
                    r_rptr[i] <= r_rptr[i] + AW'(1);
                r_cnt[i] <= r_cnt[i] + (AW+1)'(w_push[i]) - (AW+1)'(w_pop[i]);
                if (w_any[i]) begin
                    r_ptr[i]      <= w_win[i];
                    r_out_data[i] <= w_head[w_win[i]][DWIDTH-1:0];
                    r_out_dest[i] <= w_head[w_win[i]][EW-1 -: 6];
                end
            end
            r_push_d    <= w_push;
            r_out_valid <= w_any;
            r_grant     <= w_grant;
            r_drops     <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < NP; o++) begin
            out_data[o*DWIDTH +: DWIDTH] = r_out_data[o];
            out_dest_addr[o*6 +: 6]      = r_out_dest[o];
            fifo_full[o]                 = (r_cnt[o] == FULL_CNT);
            fifo_empty[o]                = (r_cnt[o] == '0);
        end
    end

    assign out_valid  = r_out_valid;
    assign grant_vec  = r_grant;
    assign drop_count = r_drops;
    assign busy       = ~&fifo_empty | |r_out_valid;

endmodule

// File: tb/tb_spine_router.sv
// Directed bench for spine_router: routing, misroute drop, round-robin order, overflow,
// full parallel load and mid-stream reset, checked against hand-computed values.
module tb_spine_router;
    logic        clk;
    logic        reset;
    logic        arb_enable;
    logic [79:0] in_data;
    logic [4:0]  in_valid;
    logic [29:0] in_dest_addr;
    logic [79:0] out_data;
    logic [4:0]  out_valid;
    logic [29:0] out_dest_addr;
    logic [4:0]  fifo_full;
    logic [4:0]  fifo_empty;
    logic [7:0]  drop_count;
    logic        busy;
    logic [24:0] grant_vec;

    int total = 0;
    int bad   = 0;

    logic [5:0]  pdst [5] = '{6'b010101, 6'b010110, 6'b010111, 6'b100000, 6'b010100};
    int          psrc [5] = '{4, 0, 1, 2, 3};
    logic [79:0] expv;

    spine_router #(.DWIDTH(16), .FIFO_DEPTH(8), .GROUP_ID(4'b0101)) dut (
        .clk(clk), .reset(reset), .arb_enable(arb_enable),
        .in_data(in_data), .in_valid(in_valid), .in_dest_addr(in_dest_addr),
        .out_data(out_data), .out_valid(out_valid), .out_dest_addr(out_dest_addr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .drop_count(drop_count),
        .busy(busy), .grant_vec(grant_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [15:0] d, input logic [5:0] a);
        in_valid[p]          = 1'b1;
        in_data[p*16 +: 16]  = d;
        in_dest_addr[p*6 +: 6] = a;
    endtask

    task automatic idle();
        in_valid = '0;
    endtask

    function automatic logic [15:0] od(input int o);
        return out_data[o*16 +: 16];
    endfunction

    function automatic logic [5:0] oa(input int o);
        return out_dest_addr[o*6 +: 6];
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; arb_enable = 1'b1;
        in_data = '0; in_valid = '0; in_dest_addr = '0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_dest", out_dest_addr, 0);
        chk("rst_grant", grant_vec, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", fifo_empty, 5'b11111);
        chk("rst_full", fifo_full, 0);
        reset = 1'b0;

        // single flit leaf 1 -> leaf 2
        put(1, 16'hA5A5, 6'b010110);
        tick(); idle();
        chk("t1_empty_e0", fifo_empty, 5'b11101);
        chk("t1_busy_e0", busy, 1);
        tick();
        chk("t1_valid_e1", out_valid, 0);
        tick();
        chk("t1_valid_e2", out_valid, 5'b00100);
        chk("t1_data", od(2), 16'hA5A5);
        chk("t1_dest", oa(2), 6'b010110);
        chk("t1_grant", grant_vec, 25'h800);
        chk("t1_empty_e2", fifo_empty, 5'b11111);
        tick();
        chk("t1_valid_e3", out_valid, 0);
        chk("t1_hold", od(2), 16'hA5A5);

        // uplink route then misroute on input 4
        put(0, 16'h1234, 6'b100001);
        tick(); idle(); tick(); tick();
        chk("t2_valid", out_valid, 5'b10000);
        chk("t2_data", od(4), 16'h1234);
        chk("t2_dest", oa(4), 6'b100001);
        chk("t2_grant", grant_vec, 25'h100000);
        put(4, 16'h5678, 6'b100001);
        tick(); idle(); tick(); tick();
        chk("t2_mis_valid", out_valid, 0);
        chk("t2_mis_drop", drop_count, 1);
        chk("t2_mis_empty", fifo_empty, 5'b11111);

        // contention on output 0, two bursts
        for (int b = 0; b < 2; b++) begin
            put(0, 16'hA000 + 16'(b*16'h1000), 6'b010100);
            put(1, 16'hA001 + 16'(b*16'h1000), 6'b010100);
            put(3, 16'hA003 + 16'(b*16'h1000), 6'b010100);
            tick(); idle(); tick(); tick();
            chk("t3_valid0", out_valid, 5'b00001);
            chk("t3_data0", od(0), 16'hA000 + 16'(b*16'h1000));
            chk("t3_grant0", grant_vec, 25'h1);
            tick();
            chk("t3_data1", od(0), 16'hA001 + 16'(b*16'h1000));
            chk("t3_grant1", grant_vec, 25'h2);
            tick();
            chk("t3_data3", od(0), 16'hA003 + 16'(b*16'h1000));
            chk("t3_grant3", grant_vec, 25'h8);
            tick();
            chk("t3_idle", out_valid, 0);
        end

        // overflow with arbitration disabled
        reset = 1'b1; tick(); reset = 1'b0;
        arb_enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            put(2, 16'hC000 + 16'(n), 6'b010111);
            tick();
            if (n == 6) chk("t4_notfull", fifo_full, 0);
            if (n == 7) begin
                chk("t4_full", fifo_full, 5'b00100);
                chk("t4_empty", fifo_empty, 5'b11011);
            end
        end
        idle(); tick();
        chk("t4_drop", drop_count, 2);
        chk("t4_noout", out_valid, 0);
        chk("t4_busy", busy, 1);
        arb_enable = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("t4_drain_valid", out_valid, 5'b01000);
            chk("t4_drain_data", od(3), 16'hC000 + 16'(n));
        end
        tick();
        chk("t4_done_valid", out_valid, 0);
        chk("t4_done_empty", fifo_empty, 5'b11111);
        chk("t4_done_busy", busy, 0);

        // all five inputs to distinct outputs for 20 cycles
        for (int t = 0; t < 22; t++) begin
            if (t < 20) begin
                for (int p = 0; p < 5; p++)
                    put(p, 16'(p*256 + t), pdst[p]);
            end else begin
                idle();
            end
            tick();
            if (t >= 2) begin
                expv = '0;
                for (int o = 0; o < 5; o++)
                    expv[o*16 +: 16] = 16'(psrc[o]*256 + t - 2);
                chk("t5_valid", out_valid, 5'b11111);
                chk("t5_data", out_data, expv);
                chk("t5_grant", grant_vec, 25'h820830);
                chk("t5_full", fifo_full, 0);
            end
        end
        tick();
        chk("t5_end_valid", out_valid, 0);
        chk("t5_end_empty", fifo_empty, 5'b11111);
        chk("t5_end_drop", drop_count, 2);

        // reset with three flits buffered
        put(0, 16'hD000, 6'b010100);
        put(1, 16'hD001, 6'b010100);
        put(3, 16'hD003, 6'b010100);
        tick(); idle(); tick();
        reset = 1'b1;
        put(2, 16'hE000, 6'b010110);
        tick();
        reset = 1'b0;
        idle();
        chk("t6_valid", out_valid, 0);
        chk("t6_empty", fifo_empty, 5'b11111);
        chk("t6_drop", drop_count, 0);
        chk("t6_grant", grant_vec, 0);
        chk("t6_busy", busy, 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t6_quiet", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
